// File: rtl/plic_if.sv
// ----------------------------------------------------------------------------
// plic_if : register-bus bundle between a bus master and the PLIC.
//
//   bus_valid  master -> slave  request, held by the master until bus_ready
//   bus_write  master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  22-bit byte address (bits [1:0] ignored)
//   bus_wdata  master -> slave  write data
//   bus_ready  slave  -> master one-cycle response pulse
//   bus_rdata  slave  -> master read data, valid while bus_ready is high
// ----------------------------------------------------------------------------
interface plic_if;
   logic        bus_valid;
   logic        bus_write;
   logic [21:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport master (
      output bus_valid, bus_write, bus_addr, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_write, bus_addr, bus_wdata,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/plic.sv
// ----------------------------------------------------------------------------
// plic : platform-level interrupt controller with two contexts (M and S).
//
// Level-triggered gateways latch device requests into pending bits; each
// context picks the highest-priority enabled pending source (lowest ID on a
// tie) and raises its external-interrupt line when that priority exceeds the
// context threshold. Software claims/completes through the register bus.
//
//   clk        clock
//   rstn       synchronous active-low reset
//   irq_src    device levels, bit i = source i (bit 0 ignored)
//   bus        register bus, plic_if slave modport
//   int_m_ext  context 0 external interrupt (registered)
//   int_s_ext  context 1 external interrupt (registered)
// ----------------------------------------------------------------------------
module plic #(
   parameter int N_SRC  = 31,
   parameter int PRIO_W = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_SRC:0]   irq_src,
   plic_if.slave            bus,
   output logic             int_m_ext,
   output logic             int_s_ext
);

   localparam logic [21:0] A_PEND  = 22'h001000;
   localparam logic [21:0] A_EN0   = 22'h002000;
   localparam logic [21:0] A_EN1   = 22'h002080;
   localparam logic [21:0] A_THR0  = 22'h200000;
   localparam logic [21:0] A_CLM0  = 22'h200004;
   localparam logic [21:0] A_THR1  = 22'h201000;
   localparam logic [21:0] A_CLM1  = 22'h201004;

   // Source 0 does not exist: it never pends and its enable bit is stuck at 0.
   localparam logic [N_SRC:0] SRC_MASK = {{N_SRC{1'b1}}, 1'b0};

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PRIO_W-1:0]   r_prio [1:N_SRC];
   logic [N_SRC:0]      r_pending;
   logic [N_SRC:0]      r_inflight;
   logic [N_SRC:0]      r_en0;
   logic [N_SRC:0]      r_en1;
   logic [PRIO_W-1:0]   r_thr0;
   logic [PRIO_W-1:0]   r_thr1;
   logic [31:0]         r_rdata;
   logic                r_int_m;
   logic                r_int_s;

   logic                w_accept;
   logic [21:0]         w_addr;
   logic                w_is_prio;
   logic [9:0]          w_prio_idx;
   logic [4:0]          w_cmpl_id;
   logic [4:0]          w_best0;
   logic [4:0]          w_best1;
   logic [PRIO_W-1:0]   w_bprio0;
   logic [PRIO_W-1:0]   w_bprio1;
   logic [N_SRC:0]      w_set;
   logic [N_SRC:0]      w_claim_mask;
   logic [N_SRC:0]      w_cmpl_mask;
   logic [31:0]         w_rdata;
   logic                w_unused;

   assign w_unused   = ^bus.bus_addr[1:0];
   assign w_addr     = {bus.bus_addr[21:2], 2'b00};
   assign w_is_prio  = (w_addr[21:12] == '0);
   assign w_prio_idx = w_addr[11:2];
   assign w_cmpl_id  = bus.bus_wdata[4:0];
   assign w_accept   = (r_state == ST_IDLE) && bus.bus_valid;

   // Gateway: a source re-arms only once it is neither pending nor in flight.
   assign w_set = irq_src & ~r_pending & ~r_inflight & SRC_MASK;

   // ------------------------------------------------------------------------
   // Arbitration. A strict '>' against a running best starting at 0 both
   // excludes priority-0 sources and keeps the lowest ID on a tie.
   // ------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_best0  = '0;
      w_bprio0 = '0;
      w_best1  = '0;
      w_bprio1 = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         if (r_pending[i] && r_en0[i] && (r_prio[i] > w_bprio0)) begin
            w_best0  = 5'(i);
            w_bprio0 = r_prio[i];
         end
         if (r_pending[i] && r_en1[i] && (r_prio[i] > w_bprio1)) begin
            w_best1  = 5'(i);
            w_bprio1 = r_prio[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Register decode: read mux plus claim / complete side-effect masks.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata      = '0;
      w_claim_mask = '0;
      w_cmpl_mask  = '0;
      if (w_is_prio) begin
         for (int i = 1; i <= N_SRC; i++) begin
            if (w_prio_idx == 10'(i)) w_rdata = 32'(r_prio[i]);
         end
      end else begin
         case (w_addr)
            A_PEND: w_rdata = 32'(r_pending);
            A_EN0:  w_rdata = 32'(r_en0);
            A_EN1:  w_rdata = 32'(r_en1);
            A_THR0: w_rdata = 32'(r_thr0);
            A_THR1: w_rdata = 32'(r_thr1);
            A_CLM0: begin
               w_rdata = 32'(w_best0);
               if (w_accept && !bus.bus_write && (w_best0 != '0))
                  w_claim_mask[w_best0] = 1'b1;
               // A complete only counts for an in-flight ID enabled here.
               if (w_accept && bus.bus_write && (w_cmpl_id != '0) &&
                   (32'(w_cmpl_id) <= N_SRC) && r_inflight[w_cmpl_id] &&
                   r_en0[w_cmpl_id])
                  w_cmpl_mask[w_cmpl_id] = 1'b1;
            end
            A_CLM1: begin
               w_rdata = 32'(w_best1);
               if (w_accept && !bus.bus_write && (w_best1 != '0))
                  w_claim_mask[w_best1] = 1'b1;
               if (w_accept && bus.bus_write && (w_cmpl_id != '0) &&
                   (32'(w_cmpl_id) <= N_SRC) && r_inflight[w_cmpl_id] &&
                   r_en1[w_cmpl_id])
                  w_cmpl_mask[w_cmpl_id] = 1'b1;
            end
            default: w_rdata = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Bus FSM: accept in IDLE, respond for one cycle in RESP.
   // ------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.bus_valid) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Architectural state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: the priority array is software-visible state with a defined
         // reset value, so each entry is cleared rather than left to power-up.
         for (int i = 1; i <= N_SRC; i++) r_prio[i] <= '0;
         r_pending  <= '0;
         r_inflight <= '0;
         r_en0      <= '0;
         r_en1      <= '0;
         r_thr0     <= '0;
         r_thr1     <= '0;
         r_rdata    <= '0;
         r_int_m    <= 1'b0;
         r_int_s    <= 1'b0;
      end else begin
         r_pending  <= (r_pending | w_set) & ~w_claim_mask;
         r_inflight <= (r_inflight | w_claim_mask) & ~w_cmpl_mask;
         // The running best priority is 0 when there is no candidate.
         r_int_m    <= (w_bprio0 > r_thr0);
         r_int_s    <= (w_bprio1 > r_thr1);
         if (w_accept) begin
            if (!bus.bus_write) begin
               r_rdata <= w_rdata;
            end else if (w_is_prio) begin
               for (int i = 1; i <= N_SRC; i++) begin
                  if (w_prio_idx == 10'(i)) r_prio[i] <= bus.bus_wdata[PRIO_W-1:0];
               end
            end else begin
               case (w_addr)
                  A_EN0:   r_en0  <= bus.bus_wdata[N_SRC:0] & SRC_MASK;
                  A_EN1:   r_en1  <= bus.bus_wdata[N_SRC:0] & SRC_MASK;
                  A_THR0:  r_thr0 <= bus.bus_wdata[PRIO_W-1:0];
                  A_THR1:  r_thr1 <= bus.bus_wdata[PRIO_W-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.bus_ready = (r_state == ST_RESP);
   assign bus.bus_rdata = r_rdata;
   assign int_m_ext     = r_int_m;
   assign int_s_ext     = r_int_s;

endmodule

// File: tb/tb_plic.sv
// ----------------------------------------------------------------------------
// tb_plic : self-checking bench for plic.
//
// A transaction-level reference model (priority table, pending / in-flight
// sets, enables, thresholds) is advanced once per clock edge from the inputs
// the bench drives. After every edge the bus response and both interrupt
// lines are compared with the model; directed scenarios add constant
// expectations, and a randomized phase mixes line toggles with bus traffic.
// ----------------------------------------------------------------------------
module tb_plic;
   localparam int N = 31;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] irq_src;
   logic        int_m_ext;
   logic        int_s_ext;

   plic_if bus_if ();

   plic #(.N_SRC(N), .PRIO_W(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .irq_src   (irq_src),
      .bus       (bus_if.slave),
      .int_m_ext (int_m_ext),
      .int_s_ext (int_s_ext)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int          m_prio [32];
   bit [31:0]   m_pend, m_infl, m_en0, m_en1;
   int          m_thr0, m_thr1;
   bit          m_int_m, m_int_s, m_resp, m_rd_chk;
   bit [31:0]   m_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Highest priority level first, then lowest ID within that level.
   function automatic int m_best(input bit [31:0] en);
      for (int p = 7; p >= 1; p--)
         for (int i = 1; i <= N; i++)
            if (m_pend[i] && en[i] && m_prio[i] == p) return i;
      return 0;
   endfunction

   task automatic model_reset();
      foreach (m_prio[i]) m_prio[i] = 0;
      m_pend = 0; m_infl = 0; m_en0 = 0; m_en1 = 0; m_thr0 = 0; m_thr1 = 0;
      m_int_m = 0; m_int_s = 0; m_resp = 0; m_rd_chk = 0; m_rdata = 0;
   endtask

   // One clock edge: advance the model with the inputs held across it, then
   // compare DUT outputs 1 time unit later.
   task automatic tick();
      int b0, b1, idx;
      bit acc, ni_m, ni_s;
      bit [21:0] a;
      bit [4:0]  id;
      bit [31:0] claim, cmpl, set, rd, wd;
      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         b0   = m_best(m_en0);
         b1   = m_best(m_en1);
         ni_m = (b0 != 0) && (m_prio[b0] > m_thr0);
         ni_s = (b1 != 0) && (m_prio[b1] > m_thr1);
         acc  = !m_resp && bus_if.bus_valid;
         a    = {bus_if.bus_addr[21:2], 2'b00};
         wd   = bus_if.bus_wdata;
         id   = wd[4:0];
         idx  = int'(a) / 4;
         claim = 0; cmpl = 0; rd = 0;
         set   = irq_src & ~m_pend & ~m_infl;
         set[0] = 1'b0;
         if (acc && !bus_if.bus_write) begin
            if (a < 22'h1000) rd = (idx >= 1 && idx <= N) ? 32'(m_prio[idx]) : 0;
            else case (a)
               22'h001000: rd = m_pend;
               22'h002000: rd = m_en0;
               22'h002080: rd = m_en1;
               22'h200000: rd = 32'(m_thr0);
               22'h201000: rd = 32'(m_thr1);
               22'h200004: begin rd = 32'(b0); if (b0 != 0) claim[b0] = 1'b1; end
               22'h201004: begin rd = 32'(b1); if (b1 != 0) claim[b1] = 1'b1; end
               default:    rd = 0;
            endcase
            m_rdata = rd;
         end
         if (acc && bus_if.bus_write) begin
            if (a < 22'h1000) begin
               if (idx >= 1 && idx <= N) m_prio[idx] = int'(wd % 8);
            end else case (a)
               22'h002000: m_en0  = wd & 32'hFFFF_FFFE;
               22'h002080: m_en1  = wd & 32'hFFFF_FFFE;
               22'h200000: m_thr0 = int'(wd % 8);
               22'h201000: m_thr1 = int'(wd % 8);
               22'h200004: if (id != 0 && m_infl[id] && m_en0[id]) cmpl[id] = 1'b1;
               22'h201004: if (id != 0 && m_infl[id] && m_en1[id]) cmpl[id] = 1'b1;
               default: ;
            endcase
         end
         m_pend   = (m_pend | set) & ~claim;
         m_infl   = (m_infl | claim) & ~cmpl;
         m_int_m  = ni_m;
         m_int_s  = ni_s;
         m_resp   = acc;
         m_rd_chk = acc && !bus_if.bus_write;
      end
      #1;
      check("bus_ready", bus_if.bus_ready, m_resp);
      check("int_m_ext", int_m_ext, m_int_m);
      check("int_s_ext", int_s_ext, m_int_s);
      if (m_resp && m_rd_chk) check("bus_rdata", bus_if.bus_rdata, m_rdata);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic bus_wr(input bit [21:0] a, input bit [31:0] d);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_write = 1'b1;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = d;
      tick();
      bus_if.bus_valid = 1'b0;
      tick();
   endtask

   task automatic bus_rd(input bit [21:0] a, output logic [31:0] d);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_write = 1'b0;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = $urandom;
      tick();
      d = bus_if.bus_rdata;
      bus_if.bus_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      ticks(2);
      rstn = 1'b1;
   endtask

   logic [31:0] rd;
   int          n_ready;
   bit [4:0]    cid;

   initial begin
      rstn = 1'b0;
      irq_src = '0;
      bus_if.bus_valid = 1'b0;
      bus_if.bus_write = 1'b0;
      bus_if.bus_addr  = '0;
      bus_if.bus_wdata = '0;
      model_reset();
      ticks(2);
      check("rst_rdata", bus_if.bus_rdata, 32'h0);
      rstn = 1'b1;
      tick();

      // Basic delivery and claim/complete.
      bus_wr(22'h000014, 3);
      bus_wr(22'h002000, 32'h20);
      bus_wr(22'h200000, 0);
      irq_src[5] = 1'b1;
      tick();
      check("basic_int_lo_at_t", int_m_ext, 1'b0);
      tick();
      check("basic_int_hi_t1", int_m_ext, 1'b1);
      bus_rd(22'h200004, rd);  check("basic_claim", rd, 5);
      bus_rd(22'h001000, rd);  check("basic_pend_clr", rd, 0);
      check("basic_int_fall", int_m_ext, 1'b0);
      bus_wr(22'h200004, 5);
      ticks(2);
      bus_rd(22'h001000, rd);  check("basic_repend", rd, 32'h20);
      check("basic_int_again", int_m_ext, 1'b1);

      // Priority and tie-break.
      irq_src = '0;
      do_reset();
      bus_wr(22'h000008, 4);
      bus_wr(22'h00001C, 6);
      bus_wr(22'h000024, 6);
      bus_wr(22'h002000, 32'h284);
      irq_src = 32'h284;
      ticks(2);
      bus_rd(22'h200004, rd);  check("tie_claim1", rd, 7);
      bus_rd(22'h200004, rd);  check("tie_claim2", rd, 9);
      bus_rd(22'h200004, rd);  check("tie_claim3", rd, 2);
      bus_rd(22'h200004, rd);  check("tie_claim4", rd, 0);

      // Threshold.
      irq_src = '0;
      do_reset();
      bus_wr(22'h00000C, 2);
      bus_wr(22'h201000, 2);
      bus_wr(22'h002080, 32'h8);
      irq_src[3] = 1'b1;
      ticks(3);
      check("thr_equal_blocks", int_s_ext, 1'b0);
      bus_rd(22'h201004, rd);  check("thr_claim", rd, 3);
      bus_wr(22'h201000, 1);
      bus_wr(22'h201004, 3);
      ticks(3);
      check("thr_lower_fires", int_s_ext, 1'b1);

      // Context isolation and bogus complete.
      irq_src = '0;
      do_reset();
      bus_wr(22'h000010, 1);
      bus_wr(22'h002080, 32'h10);
      irq_src[4] = 1'b1;
      ticks(2);
      bus_rd(22'h200004, rd);  check("iso_ctx0_claim", rd, 0);
      bus_rd(22'h201004, rd);  check("iso_ctx1_claim", rd, 4);
      bus_wr(22'h200004, 4);
      ticks(2);
      bus_rd(22'h001000, rd);  check("iso_bogus_cmpl", rd, 0);
      bus_wr(22'h201004, 4);
      ticks(2);
      bus_rd(22'h001000, rd);  check("iso_real_cmpl", rd, 32'h10);

      // Bus edge cases.
      bus_wr(22'h000000, 7);
      bus_rd(22'h000000, rd);  check("prio0_reads0", rd, 0);
      bus_rd(22'h3FFFFC, rd);  check("unmapped_reads0", rd, 0);
      bus_rd(22'h000010, rd);  check("prio4_readback", rd, 1);
      bus_rd(22'h000013, rd);  check("low_addr_bits_ignored", rd, 1);
      n_ready = 0;
      bus_if.bus_valid = 1'b1;
      bus_if.bus_write = 1'b0;
      bus_if.bus_addr  = 22'h000010;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus_if.bus_ready) n_ready++;
      end
      bus_if.bus_valid = 1'b0;
      tick();
      check("held_valid_pulses", n_ready, 3);

      // Reset mid-operation.
      bus_wr(22'h000014, 3);
      bus_wr(22'h002000, 32'h20);
      irq_src = 32'h20;
      ticks(3);
      check("rst_pre_int", int_m_ext, 1'b1);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_write = 1'b0;
      bus_if.bus_addr  = 22'h001000;
      tick();
      check("rst_in_resp", bus_if.bus_ready, 1'b1);
      rstn = 1'b0;
      bus_if.bus_valid = 1'b0;
      tick();
      check("rst_ready_lo", bus_if.bus_ready, 1'b0);
      check("rst_int_lo", int_m_ext, 1'b0);
      irq_src = '0;
      rstn = 1'b1;
      tick();
      bus_rd(22'h000014, rd);  check("rst_prio5", rd, 0);
      bus_rd(22'h002000, rd);  check("rst_en0", rd, 0);
      bus_rd(22'h001000, rd);  check("rst_pend", rd, 0);
      bus_rd(22'h200000, rd);  check("rst_thr0", rd, 0);

      // Randomized traffic against the model.
      for (int it = 0; it < 500; it++) begin
         case ($urandom_range(0, 8))
            0: if ($urandom_range(0, 3) == 0) irq_src = $urandom;
               else irq_src[$urandom_range(0, 31)] ^= 1'b1;
            1: bus_wr(22'(4 * $urandom_range(0, 40)),
                      ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(1, 7)));
            2: bus_wr($urandom_range(0, 1) ? 22'h002000 : 22'h002080, $urandom);
            3: bus_wr($urandom_range(0, 1) ? 22'h200000 : 22'h201000, $urandom);
            4, 5: bus_rd($urandom_range(0, 1) ? 22'h200004 : 22'h201004, rd);
            6: begin
               cid = 5'($urandom_range(0, 31));
               if ($urandom_range(0, 3) != 0)
                  for (int k = 0; k < 32; k++)
                     if (m_infl[(int'(cid) + k) % 32]) begin
                        cid = 5'((int'(cid) + k) % 32);
                        break;
                     end
               bus_wr($urandom_range(0, 1) ? 22'h200004 : 22'h201004,
                      ($urandom & 32'hFFFF_FFE0) | 32'(cid));
            end
            7: begin
               case ($urandom_range(0, 5))
                  0: bus_rd(22'h001000, rd);
                  1: bus_rd(22'h002000, rd);
                  2: bus_rd(22'h002080, rd);
                  3: bus_rd(22'h200000, rd);
                  4: bus_rd(22'h201000, rd);
                  default: bus_rd(22'(4 * $urandom_range(0, 40)), rd);
               endcase
            end
            default: ticks($urandom_range(1, 3));
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/plic.md
# plic

Platform-level interrupt controller: collects level-triggered device interrupt lines, arbitrates them by priority and delivers one external-interrupt request per context (M and S) to the core's `int_m_ext` / `int_s_ext` inputs. It also answers the software claim/complete handshake over a memory-mapped register bus, and sits in the platform beside the timer/CLINT block.

## Interface
- `N_SRC`, 31: number of sources, IDs 1..N_SRC; ID 0 is reserved and means "none". Legal range is 1..31.
- `PRIO_W`, 3: width of the priority and threshold fields.
- `clk` input 1: clock.
- `rstn` input 1: synchronous, active-low reset.
- `irq_src` input N_SRC+1: device levels. Bit i belongs to source i; bit 0 is ignored. The lines arrive already synchronized to `clk`.
- `bus_valid` input 1: register request. The master holds it until `bus_ready`.
- `bus_write` input 1: 1 for write, 0 for read.
- `bus_addr` input 22: byte address, word aligned. Bits [1:0] are ignored.
- `bus_wdata` input 32: write data.
- `bus_ready` output 1: one-cycle response pulse.
- `bus_rdata` output 32: read data, valid while `bus_ready` is high.
- `int_m_ext` output 1: context 0 (M-mode) external interrupt, registered.
- `int_s_ext` output 1: context 1 (S-mode) external interrupt, registered.

## Operation
- **Register map.** Unmapped reads return 0; unmapped writes are ignored.
  - 0x000000+4i: `priority[i]` (RW, PRIO_W bits). Index 0 and indices above N_SRC read 0.
  - 0x001000: `pending` (RO). Bit i is source i.
  - 0x002000: `enable0` (RW). 0x002080: `enable1` (RW). Bit 0 is hardwired to 0.
  - 0x200000 / 0x201000: `threshold0` / `threshold1` (RW, PRIO_W bits).
  - 0x200004 / 0x201004: `claim0` / `claim1`. A read performs a claim; a write performs a complete.
- **Gateway, per source i.**
  - `pending[i]` sets when `irq_src[i] & ~pending[i] & ~inflight[i]`, using the current register values.
  - A claim of i clears `pending[i]` and sets `inflight[i]`.
  - A complete with `wdata[4:0]`=i clears `inflight[i]`.
  - A complete for an ID that is not in flight, or that is not enabled in that context, is ignored.
- **Arbitration, per context c.**
  - Candidate set: i with `pending[i] & enable_c[i] & priority[i]!=0`.
  - `best_c` is the candidate with the maximum priority; ties go to the lowest ID. It is 0 when there are no candidates.
  - Notification: `int_x_ext` next = (`best_c`!=0) & (`priority[best_c]` > `threshold_c`), compared unsigned.
  - A claim returns `best_c` regardless of threshold, and returns 0 when there are no candidates. Claiming 0 has no side effect.
- **Bus FSM.** Two states, IDLE and RESP.
  - IDLE: on `bus_valid`, the request is accepted at that edge. Writes, claim side effects and `bus_rdata` capture all commit at the accept edge. The FSM then moves to RESP.
  - RESP: `bus_ready`=1 for exactly one cycle, then back to IDLE. A `bus_valid` seen while in RESP is not accepted.
- **Simultaneous events.**
  - Claim and gateway set at the same edge on different sources: both apply.
  - Complete of i while `irq_src[i]` stays high: `inflight` clears at the accept edge, and `pending[i]` re-sets one edge later.
  - A priority, enable or threshold write affects arbitration starting the cycle after the accept edge.
- **Reset values.** All priority, enable, threshold, pending and inflight state is 0. All outputs are 0. FSM is IDLE. Reset during RESP aborts the response: `bus_ready` is 0 on the next cycle.

## Timing
- `irq_src[i]` rising before edge t sets `pending` at edge t; `int_x_ext` is high after edge t+1 (2 cycles from the line to the core).
- Bus: request accepted at edge t; `bus_ready` and `bus_rdata` are valid during cycle t+1. Back-to-back transactions run at one every 2 cycles at best.
- Claim at accept edge t: `pending` clears at t; `int_x_ext` reflects the new state after edge t+1.
- `bus_rdata` holds its last value outside RESP. Its reset value is 0.

## Test plan
- **Basic delivery and claim/complete.**
  - Setup: `priority[5]`=3, `enable0`=0x20, `threshold0`=0; raise `irq_src[5]`.
  - `int_m_ext`=1 two cycles after the edge. Read 0x200004 returns 5.
  - `pending` reads 0, and `int_m_ext` falls after one cycle.
  - Write 5 to 0x200004 with the line still high: `pending[5]` re-sets and `int_m_ext` rises again.
- **Priority and tie-break.**
  - Setup: `priority[2]`=4, `priority[7]`=6, `priority[9]`=6, all enabled in ctx0, all lines high.
  - Successive claims return 7, then 9, then 2, then 0.
- **Threshold.**
  - Setup: `priority[3]`=2, `threshold1`=2, `enable1`=0x8, line high.
  - `int_s_ext` stays 0, yet a claim at 0x201004 returns 3.
  - Set `threshold1`=1 instead: `int_s_ext`=1.
- **Context isolation and bogus complete.**
  - Setup: source 4 enabled only in ctx1.
  - A ctx0 claim returns 0. A ctx0 complete of 4 leaves `inflight[4]` set, so no re-pend occurs.
  - A ctx1 complete of 4 clears it.
- **Bus edge cases.**
  - Read of 0x000000 returns 0, and a write there is ignored.
  - Read of unmapped 0x3FFFFC returns 0.
  - `bus_ready` pulses for exactly 1 cycle per request, including while `bus_valid` is held high.
- **Reset mid-operation.**
  - Assert `rstn`=0 during RESP with source pending.
  - The next cycle shows `bus_ready`=0 and `int_m_ext`=0, and all registers read 0 afterwards.
